// File: rtl/enc8to3_pend_pkg.sv
// rtl/enc8to3_pend_pkg.sv - shared types, defaults and helpers for the pending encoder
//
// Purpose: default sizing, FSM state type and the one-hot / popcount helpers
//          used by the pending encoder top.
// Ports:   none (package)
package enc8to3_pend_pkg;

  localparam int N_DEF = 8;
  localparam int W_DEF = 3;

  // Helpers work on a wide fixed vector; callers size-cast to their own N.
  localparam int MAX_N = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } enc_st_t;

  function automatic logic [MAX_N-1:0] onehot_f(input int unsigned idx);
    return MAX_N'(1) << idx;
  endfunction

  function automatic int unsigned popcnt_f(input logic [MAX_N-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_N; i++) begin
      cnt = cnt + int'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/enc8to3_pend_if.sv
// rtl/enc8to3_pend_if.sv - index offer handshake between encoder and consumer
//
// Purpose: bundles the offered index with its valid/ready handshake.
// Signals: code_o  W  offered index
//          valid_o 1  code_o is valid
//          ready_i 1  consumer accepts code_o (handshake = valid_o & ready_i)
// Modports: master = encoder side, slave = consumer side.
interface enc8to3_pend_if
  import enc8to3_pend_pkg::*;
#(
  parameter int W = W_DEF
);
  logic [W-1:0] code_o;
  logic         valid_o;
  logic         ready_i;

  modport master (output code_o, output valid_o, input ready_i);
  modport slave  (input code_o, input valid_o, output ready_i);
endinterface

// File: rtl/enc8to3_pend_prio_pick.sv
// rtl/enc8to3_pend_prio_pick.sv - combinational fixed / rotating priority search
//
// Purpose: returns the first set bit of vec, scanning from 0 (rr=0) or from
//          ptr upward with wrap (rr=1).
// Ports:   vec  in  N  candidate bits
//          ptr  in  W  scan start when rr=1 (must be < N)
//          rr   in  1  1 = rotate scan start to ptr
//          idx  out W  index of the chosen bit (0 when none)
//          any  out 1  vec has at least one set bit
module enc8to3_pend_prio_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] ptr,
  input  logic         rr,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] base;
  logic [N-1:0] rot;

  assign base = rr ? ptr : '0;
  // Rotate right by base: rot[k] corresponds to vec[(k + base) mod N].
  assign rot  = N'({vec, vec} >> base);

  // Scan downward so the lowest rotated position is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        idx = W'((int'(base) + k) % N);
      end
    end
  end

endmodule

// File: rtl/enc8to3_pend.sv
// rtl/enc8to3_pend.sv - sticky-pending 8-to-3 encoder with valid/ready index output
//
// Purpose: latches request lines into sticky pending bits and offers one
//          binary index per cycle; a bit clears only when its index is accepted.
// Ports:   clk      in  1  clock, rising edge
//          rst_n    in  1  asynchronous active-low reset
//          req_i    in  N  request lines, OR'd into pending every edge
//          clr_i    in  1  synchronous flush of pending, offer and RR pointer
//          out_if   master  code_o / valid_o / ready_i handshake
//          pend_o   out N  pending register (offered bit stays until accepted)
//          multi_o  out 1  more than one pending bit
module enc8to3_pend
  import enc8to3_pend_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter int RR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_i,
  input  logic                 clr_i,
  enc8to3_pend_if.master       out_if,
  output logic [N-1:0]         pend_o,
  output logic                 multi_o
);

  enc_st_t      state_q, state_d;
  logic [W-1:0] code_q,  code_d;
  logic [N-1:0] pend_q,  pend_d;
  logic [W-1:0] ptr_q,   ptr_d;

  logic         valid;
  logic         hs;
  logic [N-1:0] served;
  logic [N-1:0] avail;
  logic [W-1:0] ptr_adv;
  logic [W-1:0] ptr_eff;
  logic [W-1:0] pick_idx;
  logic         pick_any;

  assign valid   = (state_q == ST_OFFER);
  assign hs      = valid & out_if.ready_i;
  assign served  = hs ? N'(onehot_f(int'(code_q))) : '0;

  // While stalled nothing may be picked, so the offer cannot be preempted.
  assign avail   = (valid & ~out_if.ready_i) ? '0 : (pend_q & ~served);

  // Explicit wrap keeps the pointer inside 0..N-1 for any N.
  assign ptr_adv = (int'(code_q) == N - 1) ? '0 : code_q + W'(1);
  // Scan from the post-handshake pointer so back-to-back picks rotate too.
  assign ptr_eff = hs ? ptr_adv : ptr_q;

  enc8to3_pend_prio_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .vec (avail),
    .ptr (ptr_eff),
    .rr  (RR != 0),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pend_d  = (pend_q & ~served) | req_i;
    ptr_d   = ptr_eff;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          code_d  = pick_idx;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (out_if.ready_i) begin
          if (pick_any) begin
            code_d = pick_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over requests and a concurrent handshake.
    if (clr_i) begin
      state_d = ST_IDLE;
      code_d  = '0;
      pend_d  = '0;
      ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      pend_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_if.code_o  = code_q;
  assign out_if.valid_o = valid;
  assign pend_o         = pend_q;
  assign multi_o        = popcnt_f(MAX_N'(pend_q)) > 1;

endmodule

// File: tb/tb_enc8to3_pend.sv
// tb/tb_enc8to3_pend.sv - directed bench for the pending 8-to-3 encoder
module tb_enc8to3_pend;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       clr;
  logic       ready;
  logic [7:0] pend_fp, pend_rr;
  logic       multi_fp, multi_rr;

  int nvec;
  int nerr;

  enc8to3_pend_if #(.W(3)) bus_fp ();
  enc8to3_pend_if #(.W(3)) bus_rr ();

  assign bus_fp.ready_i = ready;
  assign bus_rr.ready_i = ready;

  enc8to3_pend #(.N(8), .W(3), .RR(0)) dut_fp (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req),
    .clr_i   (clr),
    .out_if  (bus_fp),
    .pend_o  (pend_fp),
    .multi_o (multi_fp)
  );

  enc8to3_pend #(.N(8), .W(3), .RR(1)) dut_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req),
    .clr_i   (clr),
    .out_if  (bus_rr),
    .pend_o  (pend_rr),
    .multi_o (multi_rr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic flush;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = '0; clr = 1'b0; ready = 1'b0;
    tick(); tick();
    nvec++;
    if (bus_fp.valid_o !== 1'b0 || bus_fp.code_o !== 3'd0 || pend_fp !== 8'h00) begin
      nerr++;
      $display("FAIL reset_init: valid=%b code=%0d pend=%h, want 0/0/00", bus_fp.valid_o, bus_fp.code_o, pend_fp);
    end
    rst_n = 1'b1;
    req = 8'h20;
    tick();
    req = 8'h00;
    tick();
    nvec++;
    if (bus_fp.valid_o !== 1'b1 || bus_fp.code_o !== 3'd5) begin
      nerr++;
      $display("FAIL reset_preoffer: valid=%b code=%0d, want 1/5", bus_fp.valid_o, bus_fp.code_o);
    end
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (bus_fp.valid_o !== 1'b0 || bus_fp.code_o !== 3'd0 || pend_fp !== 8'h00) begin
      nerr++;
      $display("FAIL reset_async: valid=%b code=%0d pend=%h, want 0/0/00", bus_fp.valid_o, bus_fp.code_o, pend_fp);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    ready = 1'b1;
    req = 8'h20;
    tick();
    req = 8'h00;
    nvec++;
    if (bus_fp.valid_o !== 1'b0 || pend_fp !== 8'h20) begin
      nerr++;
      $display("FAIL single_k: valid=%b pend=%h, want 0/20", bus_fp.valid_o, pend_fp);
    end
    tick();
    nvec++;
    if (bus_fp.valid_o !== 1'b1 || bus_fp.code_o !== 3'd5) begin
      nerr++;
      $display("FAIL single_k1: valid=%b code=%0d, want 1/5", bus_fp.valid_o, bus_fp.code_o);
    end
    tick();
    nvec++;
    if (bus_fp.valid_o !== 1'b0 || pend_fp !== 8'h00) begin
      nerr++;
      $display("FAIL single_k2: valid=%b pend=%h, want 0/00", bus_fp.valid_o, pend_fp);
    end
    tick();
    nvec++;
    if (bus_fp.valid_o !== 1'b0) begin
      nerr++;
      $display("FAIL single_idle_ready: valid=%b, want 0", bus_fp.valid_o);
    end
  endtask

  task automatic test_fixed_burst;
    logic [2:0] exp_code [4];
    logic [7:0] exp_pend [4];
    logic       exp_multi[4];
    exp_code  = '{3'd0, 3'd2, 3'd5, 3'd7};
    exp_pend  = '{8'hA5, 8'hA4, 8'hA0, 8'h80};
    exp_multi = '{1'b1, 1'b1, 1'b1, 1'b0};
    ready = 1'b1;
    req = 8'hA5;
    tick();
    req = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      nvec++;
      if (bus_fp.valid_o !== 1'b1 || bus_fp.code_o !== exp_code[i] ||
          pend_fp !== exp_pend[i] || multi_fp !== exp_multi[i]) begin
        nerr++;
        $display("FAIL burst_%0d: valid=%b code=%0d pend=%h multi=%b, want 1/%0d/%h/%b",
                 i, bus_fp.valid_o, bus_fp.code_o, pend_fp, multi_fp,
                 exp_code[i], exp_pend[i], exp_multi[i]);
      end
    end
    tick();
    nvec++;
    if (bus_fp.valid_o !== 1'b0 || pend_fp !== 8'h00 || multi_fp !== 1'b0) begin
      nerr++;
      $display("FAIL burst_end: valid=%b pend=%h multi=%b, want 0/00/0", bus_fp.valid_o, pend_fp, multi_fp);
    end
  endtask

  task automatic test_backpressure;
    ready = 1'b0;
    req = 8'h0C;
    tick();
    req = 8'h00;
    tick();
    nvec++;
    if (bus_fp.valid_o !== 1'b1 || bus_fp.code_o !== 3'd2) begin
      nerr++;
      $display("FAIL bp_first: valid=%b code=%0d, want 1/2", bus_fp.valid_o, bus_fp.code_o);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req = 8'h01;
      tick();
      req = 8'h00;
      nvec++;
      if (bus_fp.valid_o !== 1'b1 || bus_fp.code_o !== 3'd2) begin
        nerr++;
        $display("FAIL bp_stall_%0d: valid=%b code=%0d, want 1/2", i, bus_fp.valid_o, bus_fp.code_o);
      end
    end
    nvec++;
    if (pend_fp !== 8'h0D) begin
      nerr++;
      $display("FAIL bp_pend: pend=%h, want 0d", pend_fp);
    end
    ready = 1'b1;
    tick();
    nvec++;
    if (bus_fp.valid_o !== 1'b1 || bus_fp.code_o !== 3'd0) begin
      nerr++;
      $display("FAIL bp_rel0: valid=%b code=%0d, want 1/0", bus_fp.valid_o, bus_fp.code_o);
    end
    tick();
    nvec++;
    if (bus_fp.valid_o !== 1'b1 || bus_fp.code_o !== 3'd3) begin
      nerr++;
      $display("FAIL bp_rel3: valid=%b code=%0d, want 1/3", bus_fp.valid_o, bus_fp.code_o);
    end
    tick();
    nvec++;
    if (bus_fp.valid_o !== 1'b0 || pend_fp !== 8'h00) begin
      nerr++;
      $display("FAIL bp_end: valid=%b pend=%h, want 0/00", bus_fp.valid_o, pend_fp);
    end
  endtask

  task automatic test_round_robin;
    flush();
    ready = 1'b1;
    req = 8'h11;
    tick();
    req = 8'h00;
    tick();
    nvec++;
    if (bus_rr.valid_o !== 1'b1 || bus_rr.code_o !== 3'd0) begin
      nerr++;
      $display("FAIL rr_g0: valid=%b code=%0d, want 1/0", bus_rr.valid_o, bus_rr.code_o);
    end
    req = 8'h01;
    tick();
    req = 8'h00;
    nvec++;
    if (bus_rr.valid_o !== 1'b1 || bus_rr.code_o !== 3'd4) begin
      nerr++;
      $display("FAIL rr_g4: valid=%b code=%0d, want 1/4", bus_rr.valid_o, bus_rr.code_o);
    end
    tick();
    nvec++;
    if (bus_rr.valid_o !== 1'b1 || bus_rr.code_o !== 3'd0) begin
      nerr++;
      $display("FAIL rr_g0b: valid=%b code=%0d, want 1/0", bus_rr.valid_o, bus_rr.code_o);
    end
    tick();
    nvec++;
    if (bus_rr.valid_o !== 1'b0 || pend_rr !== 8'h00) begin
      nerr++;
      $display("FAIL rr_idle: valid=%b pend=%h, want 0/00", bus_rr.valid_o, pend_rr);
    end
    // Grant 6 moves the pointer to 7.
    req = 8'h40;
    tick();
    req = 8'h00;
    tick();
    tick();
    // Only bit 7 pending with ptr=7.
    req = 8'h80;
    tick();
    req = 8'h00;
    tick();
    nvec++;
    if (bus_rr.valid_o !== 1'b1 || bus_rr.code_o !== 3'd7) begin
      nerr++;
      $display("FAIL rr_g7: valid=%b code=%0d, want 1/7", bus_rr.valid_o, bus_rr.code_o);
    end
    tick();
    // Pointer wrapped to 0: bit 0 must win over bit 7.
    req = 8'h81;
    tick();
    req = 8'h00;
    tick();
    nvec++;
    if (bus_rr.valid_o !== 1'b1 || bus_rr.code_o !== 3'd0) begin
      nerr++;
      $display("FAIL rr_wrap0: valid=%b code=%0d, want 1/0", bus_rr.valid_o, bus_rr.code_o);
    end
    tick();
    nvec++;
    if (bus_rr.valid_o !== 1'b1 || bus_rr.code_o !== 3'd7) begin
      nerr++;
      $display("FAIL rr_wrap7: valid=%b code=%0d, want 1/7", bus_rr.valid_o, bus_rr.code_o);
    end
    tick();
  endtask

  task automatic test_flush;
    flush();
    ready = 1'b1;
    // Grant 2 so the RR pointer sits at 3.
    req = 8'h04;
    tick();
    req = 8'h00;
    tick();
    tick();
    req = 8'hFF;
    tick();
    req = 8'h00;
    tick();
    nvec++;
    if (bus_rr.valid_o !== 1'b1 || bus_rr.code_o !== 3'd3 || bus_fp.code_o !== 3'd0) begin
      nerr++;
      $display("FAIL flush_pre: rr valid=%b code=%0d fp code=%0d, want 1/3/0", bus_rr.valid_o, bus_rr.code_o, bus_fp.code_o);
    end
    clr = 1'b1;
    req = 8'hFF;
    tick();
    clr = 1'b0;
    req = 8'h00;
    nvec++;
    if (bus_fp.valid_o !== 1'b0 || pend_fp !== 8'h00 || bus_rr.valid_o !== 1'b0 || pend_rr !== 8'h00) begin
      nerr++;
      $display("FAIL flush_edge: fp valid=%b pend=%h rr valid=%b pend=%h, want 0/00/0/00", bus_fp.valid_o, pend_fp, bus_rr.valid_o, pend_rr);
    end
    tick();
    nvec++;
    if (bus_fp.valid_o !== 1'b0 || pend_fp !== 8'h00 || bus_rr.valid_o !== 1'b0) begin
      nerr++;
      $display("FAIL flush_after: fp valid=%b pend=%h rr valid=%b, want 0/00/0", bus_fp.valid_o, pend_fp, bus_rr.valid_o);
    end
    // Pointer cleared by the flush: scan restarts at 0, so bit 1 beats bit 5.
    req = 8'h22;
    tick();
    req = 8'h00;
    tick();
    nvec++;
    if (bus_rr.valid_o !== 1'b1 || bus_rr.code_o !== 3'd1) begin
      nerr++;
      $display("FAIL flush_ptr1: valid=%b code=%0d, want 1/1", bus_rr.valid_o, bus_rr.code_o);
    end
    tick();
    nvec++;
    if (bus_rr.valid_o !== 1'b1 || bus_rr.code_o !== 3'd5) begin
      nerr++;
      $display("FAIL flush_ptr5: valid=%b code=%0d, want 1/5", bus_rr.valid_o, bus_rr.code_o);
    end
    tick();
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_single();
    test_fixed_burst();
    test_backpressure();
    test_round_robin();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
